// File: rtl/cbb_hakem_if.sv
// rtl/cbb_hakem_if.sv - requester and CBB side signals of the cbb_hakem arbiter
interface cbb_hakem_if #(
  parameter int VERI_BIT = 32,
  parameter int KOD_BIT  = 4
);
  logic                bosalt_i;
  logic [1:0]          istek_i;
  logic [KOD_BIT-1:0]  kod0_i;
  logic [KOD_BIT-1:0]  kod1_i;
  logic [VERI_BIT-1:0] islec1_0_i;
  logic [VERI_BIT-1:0] islec2_0_i;
  logic [VERI_BIT-1:0] islec1_1_i;
  logic [VERI_BIT-1:0] islec2_1_i;
  logic [1:0]          kabul_o;
  logic [VERI_BIT-1:0] sonuc_o;
  logic [1:0]          sonuc_gecerli_o;
  logic                mesgul_o;
  logic                birim_istek_o;
  logic [KOD_BIT-1:0]  birim_kod_o;
  logic [VERI_BIT-1:0] birim_islec1_o;
  logic [VERI_BIT-1:0] birim_islec2_o;
  logic                birim_hazir_i;
  logic [VERI_BIT-1:0] birim_sonuc_i;
  logic                birim_sonuc_gecerli_i;
  logic                birim_iptal_o;

  // arbiter side
  modport slave (
    input  bosalt_i, istek_i, kod0_i, kod1_i,
    input  islec1_0_i, islec2_0_i, islec1_1_i, islec2_1_i,
    input  birim_hazir_i, birim_sonuc_i, birim_sonuc_gecerli_i,
    output kabul_o, sonuc_o, sonuc_gecerli_o, mesgul_o,
    output birim_istek_o, birim_kod_o, birim_islec1_o, birim_islec2_o, birim_iptal_o
  );

  // requesters plus CBB side
  modport master (
    output bosalt_i, istek_i, kod0_i, kod1_i,
    output islec1_0_i, islec2_0_i, islec1_1_i, islec2_1_i,
    output birim_hazir_i, birim_sonuc_i, birim_sonuc_gecerli_i,
    input  kabul_o, sonuc_o, sonuc_gecerli_o, mesgul_o,
    input  birim_istek_o, birim_kod_o, birim_islec1_o, birim_islec2_o, birim_iptal_o
  );
endinterface

// File: rtl/cbb_hakem.sv
// rtl/cbb_hakem.sv - two-port round-robin sequencer for a shared mul/div unit; optional result reuse under CBB_HAKEM_SONUC_TEKRAR_EN
module cbb_hakem #(
  parameter int VERI_BIT = 32,
  parameter int KOD_BIT  = 4
) (
  input logic       clk_i,
  input logic       rstn_i,
  cbb_hakem_if.slave bus
);
  localparam logic [2:0] BOSTA  = 3'd0;
  localparam logic [2:0] GONDER = 3'd1;
  localparam logic [2:0] BEKLE  = 3'd2;
  localparam logic [2:0] TESLIM = 3'd3;
  localparam logic [2:0] IPTAL  = 3'd4;
`ifdef CBB_HAKEM_SONUC_TEKRAR_EN
  localparam logic [2:0] TEKRAR = 3'd5;
`endif

  logic [2:0]          r_state;
  logic [2:0]          w_state_nx;
  logic                r_oncelik;
  logic                r_id;
  logic [KOD_BIT-1:0]  r_kod;
  logic [VERI_BIT-1:0] r_islec1;
  logic [VERI_BIT-1:0] r_islec2;
  logic [VERI_BIT-1:0] r_sonuc;

  logic                w_basla;
  logic                w_grant_id;
  logic [KOD_BIT-1:0]  w_kod;
  logic [VERI_BIT-1:0] w_islec1;
  logic [VERI_BIT-1:0] w_islec2;
  logic [1:0]          w_id_onehot;
  logic                w_kabul_en;

  // a new operation starts only from idle and never during a flush
  assign w_basla    = (r_state == BOSTA) && (|bus.istek_i) && !bus.bosalt_i;
  // on contention the priority bit decides, otherwise the lone requester wins
  assign w_grant_id = (bus.istek_i == 2'b11) ? r_oncelik : bus.istek_i[1];
  assign w_kod      = w_grant_id ? bus.kod1_i     : bus.kod0_i;
  assign w_islec1   = w_grant_id ? bus.islec1_1_i : bus.islec1_0_i;
  assign w_islec2   = w_grant_id ? bus.islec2_1_i : bus.islec2_0_i;
  assign w_id_onehot = r_id ? 2'b10 : 2'b01;

`ifdef CBB_HAKEM_SONUC_TEKRAR_EN
  logic                r_tv;
  logic [KOD_BIT-1:0]  r_tkod;
  logic [VERI_BIT-1:0] r_tislec1;
  logic [VERI_BIT-1:0] r_tislec2;
  logic [VERI_BIT-1:0] r_tsonuc;
  logic                w_hit;

  assign w_hit = r_tv && (w_kod == r_tkod) && (w_islec1 == r_tislec1) && (w_islec2 == r_tislec2);

  // remember the last operation that was actually delivered to its requester
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_tv      <= 1'b0;
      r_tkod    <= '0;
      r_tislec1 <= '0;
      r_tislec2 <= '0;
      r_tsonuc  <= '0;
    end else if (r_state == TESLIM && !bus.bosalt_i) begin
      r_tv      <= 1'b1;
      r_tkod    <= r_kod;
      r_tislec1 <= r_islec1;
      r_tislec2 <= r_islec2;
      r_tsonuc  <= r_sonuc;
    end
  end

  assign w_kabul_en = !bus.bosalt_i &&
                      ((r_state == GONDER && bus.birim_hazir_i) || r_state == TEKRAR);
`else
  assign w_kabul_en = !bus.bosalt_i && (r_state == GONDER) && bus.birim_hazir_i;
`endif

  // next-state selection; flush always wins over progress
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      BOSTA: begin
`ifdef CBB_HAKEM_SONUC_TEKRAR_EN
        if (w_basla) w_state_nx = w_hit ? TEKRAR : GONDER;
`else
        if (w_basla) w_state_nx = GONDER;
`endif
      end
      GONDER: begin
        if (bus.bosalt_i)           w_state_nx = BOSTA;
        else if (bus.birim_hazir_i) w_state_nx = BEKLE;
      end
      BEKLE: begin
        if (bus.birim_sonuc_gecerli_i) w_state_nx = bus.bosalt_i ? BOSTA : TESLIM;
        else if (bus.bosalt_i)         w_state_nx = IPTAL;
      end
      TESLIM: w_state_nx = BOSTA;
      IPTAL: begin
        if (bus.birim_hazir_i) w_state_nx = BOSTA;
      end
`ifdef CBB_HAKEM_SONUC_TEKRAR_EN
      TEKRAR: w_state_nx = bus.bosalt_i ? BOSTA : TESLIM;
`endif
      default: w_state_nx = BOSTA;
    endcase
  end

  // state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= BOSTA;
    else         r_state <= w_state_nx;
  end

  // grant id and operands are frozen at grant so the CBB sees stable values
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_id     <= 1'b0;
      r_kod    <= '0;
      r_islec1 <= '0;
      r_islec2 <= '0;
    end else if (w_basla) begin
      r_id     <= w_grant_id;
      r_kod    <= w_kod;
      r_islec1 <= w_islec1;
      r_islec2 <= w_islec2;
    end
  end

  // the served requester yields priority, even if its delivery was flushed
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                 r_oncelik <= 1'b0;
    else if (r_state == TESLIM)  r_oncelik <= ~r_id;
  end

  // result capture; a result arriving together with a flush is dropped
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sonuc <= '0;
    end else if (r_state == BEKLE && bus.birim_sonuc_gecerli_i && !bus.bosalt_i) begin
      r_sonuc <= bus.birim_sonuc_i;
`ifdef CBB_HAKEM_SONUC_TEKRAR_EN
    end else if (r_state == TEKRAR) begin
      r_sonuc <= r_tsonuc;
`endif
    end
  end

  assign bus.mesgul_o        = (r_state != BOSTA);
  assign bus.birim_istek_o   = (r_state == GONDER) && !bus.bosalt_i;
  assign bus.birim_kod_o     = r_kod;
  assign bus.birim_islec1_o  = r_islec1;
  assign bus.birim_islec2_o  = r_islec2;
  assign bus.kabul_o         = w_kabul_en ? w_id_onehot : 2'b00;
  assign bus.sonuc_o         = r_sonuc;
  assign bus.sonuc_gecerli_o = (r_state == TESLIM && !bus.bosalt_i) ? w_id_onehot : 2'b00;
  assign bus.birim_iptal_o   = (r_state == BEKLE) && bus.bosalt_i && !bus.birim_sonuc_gecerli_i;
endmodule

// File: tb/tb_cbb_hakem.sv
// tb/tb_cbb_hakem.sv - self-checking bench for cbb_hakem
module tb_cbb_hakem;
  localparam int VB = 32;
  localparam int KB = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cbb_hakem_if #(.VERI_BIT(VB), .KOD_BIT(KB)) bus ();
  cbb_hakem #(.VERI_BIT(VB), .KOD_BIT(KB)) dut (.clk_i(clk), .rstn_i(rstn), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] op(input logic [3:0] k, input logic [31:0] a, input logic [31:0] b);
    case (k)
      4'd1:    return a * b;
      4'd2:    return (b == 0) ? 32'd0 : a / b;
      default: return a + b;
    endcase
  endfunction

  typedef struct {
    logic [1:0]  istek;
    logic        bos, hz, sg;
    logic [31:0] bs, a1, b0;
    logic [1:0]  kab, sgo;
    logic        mes, bi, ipt;
    logic [31:0] son, bl1;
  } vec_t;
  vec_t tbl [0:39];

  task automatic sv(input int i, input logic [1:0] ist, input logic bos, input logic hz, input logic sg,
                    input logic [31:0] bs, input logic [31:0] a1, input logic [31:0] b0,
                    input logic [1:0] kab, input logic [1:0] sgo, input logic mes, input logic bi,
                    input logic ipt, input logic [31:0] son, input logic [31:0] bl1);
    tbl[i].istek = ist; tbl[i].bos = bos; tbl[i].hz = hz; tbl[i].sg = sg;
    tbl[i].bs = bs; tbl[i].a1 = a1; tbl[i].b0 = b0;
    tbl[i].kab = kab; tbl[i].sgo = sgo; tbl[i].mes = mes; tbl[i].bi = bi;
    tbl[i].ipt = ipt; tbl[i].son = son; tbl[i].bl1 = bl1;
  endtask

  task automatic zero_inputs();
    bus.bosalt_i = 0; bus.istek_i = 0; bus.kod0_i = 0; bus.kod1_i = 0;
    bus.islec1_0_i = 0; bus.islec2_0_i = 0; bus.islec1_1_i = 0; bus.islec2_1_i = 0;
    bus.birim_hazir_i = 0; bus.birim_sonuc_i = 0; bus.birim_sonuc_gecerli_i = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " mesgul"}, bus.mesgul_o, 0);
    chk({tag, " kabul"}, bus.kabul_o, 0);
    chk({tag, " sonuc_gecerli"}, bus.sonuc_gecerli_o, 0);
    chk({tag, " sonuc"}, bus.sonuc_o, 0);
    chk({tag, " birim_istek"}, bus.birim_istek_o, 0);
    chk({tag, " iptal"}, bus.birim_iptal_o, 0);
    chk({tag, " birim_kod"}, bus.birim_kod_o, 0);
    chk({tag, " birim_islec1"}, bus.birim_islec1_o, 0);
    chk({tag, " birim_islec2"}, bus.birim_islec2_o, 0);
  endtask

  // requester 0 issues MUL 7x6; a CBB with latency 2 answers; cycle 0 is the grant cycle
  task automatic run_mul(output int bi_at, output int kab_at, output int sg_at, output logic [31:0] res);
    logic busy, strobe, done;
    int cnt;
    logic [31:0] cres;
    busy = 0; cnt = 0; cres = 0; done = 0;
    bi_at = -1; kab_at = -1; sg_at = -1; res = 0;
    bus.kod0_i = 4'd1; bus.islec1_0_i = 7; bus.islec2_0_i = 6;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      bus.istek_i = done ? 2'b00 : 2'b01;
      strobe = busy && (cnt == 0);
      bus.birim_hazir_i = !busy;
      bus.birim_sonuc_gecerli_i = strobe;
      bus.birim_sonuc_i = cres;
      #2;
      if (done) break;
      if (bus.birim_istek_o && bi_at < 0) bi_at = c;
      if (bus.kabul_o != 0 && kab_at < 0) kab_at = c;
      if (bus.sonuc_gecerli_o[0]) begin sg_at = c; res = bus.sonuc_o; done = 1; end
      if (strobe) busy = 0;
      else if (busy) cnt--;
      if (bus.birim_istek_o && bus.birim_hazir_i) begin
        busy = 1; cnt = 1;
        cres = op(bus.birim_kod_o, bus.birim_islec1_o, bus.birim_islec2_o);
      end
    end
    bus.birim_sonuc_gecerli_i = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bi_at, kab_at, sg_at;
    logic [31:0] res;
    logic act [2];
    logic [3:0] rk [2];
    logic [31:0] ra [2], rb [2];
    int idle [2];
    logic arb_idle, arb_id, pri, g_now, gid;
    logic cbusy, strobe, strobe_prev;
    int ccnt, n_done;
    logic [31:0] cres;
    logic [1:0] exp_sg;

    //        ist    bos hz sg bs   a1   b0  kab    sgo    mes bi ipt son  bl1
    sv( 0, 2'b01, 0, 1, 0,  0, 100, 6, 2'b00, 2'b00, 0, 0, 0,  0,   0);
    sv( 1, 2'b01, 0, 1, 0,  0, 100, 6, 2'b01, 2'b00, 1, 1, 0,  0,   7);
    sv( 2, 2'b01, 0, 0, 0,  0, 100, 6, 2'b00, 2'b00, 1, 0, 0,  0,   7);
    sv( 3, 2'b01, 0, 0, 0,  0, 100, 6, 2'b00, 2'b00, 1, 0, 0,  0,   7);
    sv( 4, 2'b01, 0, 0, 0,  0, 100, 6, 2'b00, 2'b00, 1, 0, 0,  0,   7);
    sv( 5, 2'b01, 0, 0, 1, 42, 100, 6, 2'b00, 2'b00, 1, 0, 0,  0,   7);
    sv( 6, 2'b01, 0, 1, 0,  0, 100, 6, 2'b00, 2'b01, 1, 0, 0, 42,   7);
    sv( 7, 2'b00, 0, 1, 0,  0, 100, 6, 2'b00, 2'b00, 0, 0, 0, 42,   7);
    sv( 8, 2'b10, 0, 0, 0,  0, 100, 6, 2'b00, 2'b00, 0, 0, 0, 42,   7);
    sv( 9, 2'b10, 0, 0, 0,  0, 100, 6, 2'b00, 2'b00, 1, 1, 0, 42, 100);
    sv(10, 2'b10, 0, 0, 0,  0,  55, 6, 2'b00, 2'b00, 1, 1, 0, 42, 100);
    sv(11, 2'b10, 0, 0, 0,  0,  55, 6, 2'b00, 2'b00, 1, 1, 0, 42, 100);
    sv(12, 2'b10, 0, 0, 0,  0,  55, 6, 2'b00, 2'b00, 1, 1, 0, 42, 100);
    sv(13, 2'b10, 0, 0, 0,  0, 100, 6, 2'b00, 2'b00, 1, 1, 0, 42, 100);
    sv(14, 2'b10, 0, 1, 0,  0, 100, 6, 2'b10, 2'b00, 1, 1, 0, 42, 100);
    sv(15, 2'b10, 0, 0, 0,  0, 100, 6, 2'b00, 2'b00, 1, 0, 0, 42, 100);
    sv(16, 2'b10, 1, 0, 0,  0, 100, 6, 2'b00, 2'b00, 1, 0, 1, 42, 100);
    sv(17, 2'b00, 0, 0, 1, 20, 100, 6, 2'b00, 2'b00, 1, 0, 0, 42, 100);
    sv(18, 2'b00, 0, 0, 0,  0, 100, 6, 2'b00, 2'b00, 1, 0, 0, 42, 100);
    sv(19, 2'b00, 0, 1, 0,  0, 100, 6, 2'b00, 2'b00, 1, 0, 0, 42, 100);
    sv(20, 2'b01, 0, 1, 0,  0, 100, 8, 2'b00, 2'b00, 0, 0, 0, 42, 100);
    sv(21, 2'b01, 0, 1, 0,  0, 100, 8, 2'b01, 2'b00, 1, 1, 0, 42,   7);
    sv(22, 2'b01, 1, 0, 1, 99, 100, 8, 2'b00, 2'b00, 1, 0, 0, 42,   7);
    sv(23, 2'b10, 0, 1, 0,  0, 100, 8, 2'b00, 2'b00, 0, 0, 0, 42,   7);
    sv(24, 2'b10, 0, 1, 0,  0, 100, 8, 2'b10, 2'b00, 1, 1, 0, 42, 100);
    sv(25, 2'b10, 0, 0, 1, 43, 100, 8, 2'b00, 2'b00, 1, 0, 0, 42, 100);
    sv(26, 2'b10, 1, 0, 0,  0, 100, 8, 2'b00, 2'b00, 1, 0, 0, 43, 100);
    sv(27, 2'b11, 0, 1, 0,  0, 100, 8, 2'b00, 2'b00, 0, 0, 0, 43, 100);
    sv(28, 2'b11, 0, 1, 0,  0, 100, 8, 2'b01, 2'b00, 1, 1, 0, 43,   7);
    sv(29, 2'b11, 0, 0, 1, 56, 100, 8, 2'b00, 2'b00, 1, 0, 0, 43,   7);
    sv(30, 2'b11, 0, 1, 0,  0, 100, 8, 2'b00, 2'b01, 1, 0, 0, 56,   7);
    sv(31, 2'b11, 0, 1, 0,  0, 100, 8, 2'b00, 2'b00, 0, 0, 0, 56,   7);
    sv(32, 2'b11, 0, 1, 0,  0, 100, 8, 2'b10, 2'b00, 1, 1, 0, 56, 100);
    sv(33, 2'b11, 0, 0, 1, 20, 100, 8, 2'b00, 2'b00, 1, 0, 0, 56, 100);
    sv(34, 2'b11, 0, 1, 0,  0, 100, 8, 2'b00, 2'b10, 1, 0, 0, 20, 100);
    sv(35, 2'b11, 0, 1, 0,  0, 100, 8, 2'b00, 2'b00, 0, 0, 0, 20, 100);
    sv(36, 2'b11, 0, 1, 0,  0, 100, 8, 2'b01, 2'b00, 1, 1, 0, 20,   7);
    sv(37, 2'b11, 0, 0, 1, 56, 100, 8, 2'b00, 2'b00, 1, 0, 0, 20,   7);
    sv(38, 2'b00, 0, 1, 0,  0, 100, 8, 2'b00, 2'b01, 1, 0, 0, 56,   7);
    sv(39, 2'b00, 0, 1, 0,  0, 100, 8, 2'b00, 2'b00, 0, 0, 0, 56,   7);

    zero_inputs();
    rstn = 0;
    repeat (2) @(negedge clk);
    #2;
    chk_zero("reset");
    rstn = 1;

    bus.kod0_i = 4'd1; bus.islec1_0_i = 7;
    bus.kod1_i = 4'd2; bus.islec2_1_i = 5;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.istek_i = tbl[i].istek; bus.bosalt_i = tbl[i].bos;
      bus.birim_hazir_i = tbl[i].hz; bus.birim_sonuc_gecerli_i = tbl[i].sg;
      bus.birim_sonuc_i = tbl[i].bs; bus.islec1_1_i = tbl[i].a1; bus.islec2_0_i = tbl[i].b0;
      #2;
      chk($sformatf("row%0d kabul", i), bus.kabul_o, tbl[i].kab);
      chk($sformatf("row%0d sonuc_gecerli", i), bus.sonuc_gecerli_o, tbl[i].sgo);
      chk($sformatf("row%0d mesgul", i), bus.mesgul_o, tbl[i].mes);
      chk($sformatf("row%0d birim_istek", i), bus.birim_istek_o, tbl[i].bi);
      chk($sformatf("row%0d iptal", i), bus.birim_iptal_o, tbl[i].ipt);
      chk($sformatf("row%0d sonuc", i), bus.sonuc_o, tbl[i].son);
      chk($sformatf("row%0d birim_islec1", i), bus.birim_islec1_o, tbl[i].bl1);
    end

    // asynchronous reset while waiting for the CBB
    @(negedge clk); bus.bosalt_i = 0; bus.birim_sonuc_gecerli_i = 0;
    bus.istek_i = 2'b01; bus.birim_hazir_i = 1; #2;
    @(negedge clk); #2;
    @(negedge clk); bus.birim_hazir_i = 0; #2;
    chk("arst pre mesgul", bus.mesgul_o, 1);
    chk("arst pre sonuc", bus.sonuc_o, 56);
    #1 rstn = 0;
    #1 chk_zero("arst");
    bus.istek_i = 0;
    @(negedge clk); rstn = 1;

    // same MUL twice: reuse path only when the result store is built in
    run_mul(bi_at, kab_at, sg_at, res);
    chk("mul1 birim_istek cycle", bi_at, 1);
    chk("mul1 kabul cycle", kab_at, 1);
    chk("mul1 result cycle", sg_at, 4);
    chk("mul1 result", res, 42);
    run_mul(bi_at, kab_at, sg_at, res);
`ifdef CBB_HAKEM_SONUC_TEKRAR_EN
    chk("mul2 birim_istek cycle", bi_at, -1);
    chk("mul2 kabul cycle", kab_at, 1);
    chk("mul2 result cycle", sg_at, 2);
`else
    chk("mul2 birim_istek cycle", bi_at, 1);
    chk("mul2 kabul cycle", kab_at, 1);
    chk("mul2 result cycle", sg_at, 4);
`endif
    chk("mul2 result", res, 42);

    // randomized traffic against a transaction-level model
    @(negedge clk); rstn = 0; zero_inputs();
    @(negedge clk); rstn = 1;
    for (int i = 0; i < 2; i++) begin act[i] = 0; idle[i] = i; rk[i] = 0; ra[i] = 0; rb[i] = 1; end
    arb_idle = 1; arb_id = 0; pri = 0; cbusy = 0; ccnt = 0; cres = 0; strobe_prev = 0; n_done = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!act[i]) begin
          if (idle[i] == 0) begin
            act[i] = 1; rk[i] = 4'($urandom_range(0, 3));
            ra[i] = $urandom; rb[i] = $urandom_range(1, 1000);
          end else idle[i]--;
        end
      end
      bus.istek_i = {act[1], act[0]};
      bus.kod0_i = rk[0]; bus.islec1_0_i = ra[0]; bus.islec2_0_i = rb[0];
      bus.kod1_i = rk[1]; bus.islec1_1_i = ra[1]; bus.islec2_1_i = rb[1];
      strobe = cbusy && (ccnt == 0);
      bus.birim_hazir_i = !cbusy && ($urandom_range(0, 2) != 0);
      bus.birim_sonuc_gecerli_i = strobe;
      bus.birim_sonuc_i = strobe ? cres : $urandom;
      g_now = arb_idle && (bus.istek_i != 0);
      gid = (bus.istek_i == 2'b11) ? pri : act[1];
      #2;
      chk($sformatf("rnd%0d mesgul", c), bus.mesgul_o, !arb_idle);
      if (bus.kabul_o != 0) begin
        chk($sformatf("rnd%0d kabul", c), bus.kabul_o, arb_id ? 2'b10 : 2'b01);
        chk($sformatf("rnd%0d birim_kod", c), bus.birim_kod_o, rk[arb_id]);
        chk($sformatf("rnd%0d birim_islec1", c), bus.birim_islec1_o, ra[arb_id]);
        chk($sformatf("rnd%0d birim_islec2", c), bus.birim_islec2_o, rb[arb_id]);
      end
      exp_sg = strobe_prev ? (arb_id ? 2'b10 : 2'b01) : 2'b00;
      chk($sformatf("rnd%0d sonuc_gecerli", c), bus.sonuc_gecerli_o, exp_sg);
      if (strobe_prev) begin
        chk($sformatf("rnd%0d sonuc", c), bus.sonuc_o, op(rk[arb_id], ra[arb_id], rb[arb_id]));
        act[arb_id] = 0; idle[arb_id] = $urandom_range(0, 2);
        pri = ~arb_id; arb_idle = 1; n_done++;
      end
      if (g_now) begin arb_idle = 0; arb_id = gid; end
      strobe_prev = strobe;
      if (strobe) cbusy = 0;
      else if (cbusy) ccnt--;
      if (bus.birim_istek_o && bus.birim_hazir_i) begin
        cbusy = 1; ccnt = $urandom_range(0, 4);
        cres = op(bus.birim_kod_o, bus.birim_islec1_o, bus.birim_islec2_o);
      end
    end
    chk("rnd progress", n_done >= 40, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
